// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, widths and scan code constants.
// Used by ps2_rx_ctrl, key_decoder and ps2_status.
package ps2_pkg;

  localparam int unsigned SCAN_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [SCAN_W-1:0] SC_W     = 8'h1D;
  localparam logic [SCAN_W-1:0] SC_A     = 8'h1C;
  localparam logic [SCAN_W-1:0] SC_S     = 8'h1B;
  localparam logic [SCAN_W-1:0] SC_D     = 8'h23;
  localparam logic [SCAN_W-1:0] SC_SPACE = 8'h29;
  localparam logic [SCAN_W-1:0] SC_R     = 8'h2D;
  localparam logic [SCAN_W-1:0] SC_BREAK = 8'hF0;
  localparam logic [SCAN_W-1:0] SC_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-FF synchronizers on clock and data, a glitch filter
// on the clock, and a one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_fall,
  output logic dat_s
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_f;
  logic [CNT_W-1:0] flt_cnt;
  logic             clk_s;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // The filtered clock follows the synced clock only after it has disagreed
  // for FILTER_LEN consecutive samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      flt_cnt  <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_fall <= 1'b0;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == CNT_W'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s;
        flt_cnt  <= '0;
        clk_fall <= ~clk_s;
      end else begin
        flt_cnt <= flt_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: frames start/8 data/odd parity/stop and delivers scan codes.
// Build option: define PS2_PARITY_CHECK_EN to drop frames whose parity bit is wrong.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  input  logic              enable,
  output logic [SCAN_W-1:0] scan_code,
  output logic              scan_ready,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned WD_W   = $clog2(TO_CYC + 1);

  logic clk_fall;
  logic dat_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .clk_fall (clk_fall),
    .dat_s    (dat_s)
  );

  ps2_state_e           state,      state_nxt;
  logic [SCAN_W-1:0]    shreg,      shreg_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt,    bit_cnt_nxt;
  logic                 par_ok,     par_ok_nxt;
  logic [WD_W-1:0]      wd_cnt,     wd_nxt;
  logic [SCAN_W-1:0]    scan_code_nxt;
  logic                 scan_ready_nxt;
  logic                 frame_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      wd_cnt     <= '0;
      scan_code  <= '0;
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      par_ok     <= par_ok_nxt;
      wd_cnt     <= wd_nxt;
      scan_code  <= scan_code_nxt;
      scan_ready <= scan_ready_nxt;
      frame_err  <= frame_err_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Priority: enable abort, then a clock fall, then the watchdog expiring.
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    par_ok_nxt     = par_ok;
    scan_code_nxt  = scan_code;
    scan_ready_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    wd_nxt         = (state == ST_IDLE) ? '0 : wd_cnt + WD_W'(1);

    if (!enable) begin
      state_nxt = ST_IDLE;
      wd_nxt    = '0;
    end else if (clk_fall) begin
      wd_nxt = '0;
      case (state)
        ST_IDLE: begin
          if (!dat_s) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shreg_nxt   = {dat_s, shreg[SCAN_W-1:1]};
          bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(SCAN_W - 1)) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_ok_nxt = ^{shreg, dat_s};
`else
          par_ok_nxt = 1'b1;
`endif
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (dat_s && par_ok) begin
            scan_code_nxt  = shreg;
            scan_ready_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if ((state != ST_IDLE) && (wd_cnt == WD_W'(TO_CYC - 1))) begin
      frame_err_nxt = 1'b1;
      state_nxt     = ST_IDLE;
      wd_nxt        = '0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl. PS/2 half-period is 40us; the clock is scaled to
// 5 MHz so the 2000us watchdog is 10_000 cycles. Honors PS2_PARITY_CHECK_EN.
module tb_ps2_rx_ctrl;

  localparam int unsigned CLK_HZ     = 5_000_000;
  localparam int unsigned TIMEOUT_US = 2000;
  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TO_CYC     = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int          HALF       = 200;
  // pin fall -> 2 sync flops + FILTER_LEN filter samples + strobe flop, then TO_CYC, then output flop
  localparam int          TO_EXPECT  = int'(TO_CYC) + 11;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       enable;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_err;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;
  int ready_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  ps2_rx_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .enable     (enable),
    .scan_code  (scan_code),
    .scan_ready (scan_ready),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (scan_ready) ready_cnt++;
    if (frame_err) err_cnt++;
    if (scan_ready && frame_err) both_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_flip,
                                           input logic stop);
    logic p;
    p = (~^d) ^ par_flip;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_dat = frame[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_vec++; if (scan_code !== 8'h00) begin n_miss++; $display("FAIL reset_scan_code got=%h exp=00", scan_code); end
    n_vec++; if (scan_ready !== 1'b0) begin n_miss++; $display("FAIL reset_scan_ready got=%b exp=0", scan_ready); end
    n_vec++; if (frame_err !== 1'b0) begin n_miss++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int r0, e0;
    logic [10:0] f;
    r0 = ready_cnt; e0 = err_cnt;
    f = mk_frame(8'h1D, 1'b0, 1'b1);
    send_bits(f, 0, 3);
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL good_busy_mid got=%b exp=1", busy); end
    send_bits(f, 4, 10);
    n_vec++; if (scan_code !== 8'h1D) begin n_miss++; $display("FAIL good_scan_code got=%h exp=1d", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 1) begin n_miss++; $display("FAIL good_ready_pulses got=%0d exp=1", ready_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_miss++; $display("FAIL good_err_pulses got=%0d exp=0", err_cnt - e0); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL good_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_parity();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h29, 1'b1, 1'b1), 0, 10);
`ifdef PS2_PARITY_CHECK_EN
    n_vec++; if (scan_code !== 8'h1D) begin n_miss++; $display("FAIL parity_scan_code got=%h exp=1d", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 0) begin n_miss++; $display("FAIL parity_ready got=%0d exp=0", ready_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 1) begin n_miss++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
`else
    n_vec++; if (scan_code !== 8'h29) begin n_miss++; $display("FAIL parity_scan_code got=%h exp=29", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 1) begin n_miss++; $display("FAIL parity_ready got=%0d exp=1", ready_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_miss++; $display("FAIL parity_err got=%0d exp=0", err_cnt - e0); end
`endif
  endtask

  task automatic test_bad_stop();
    int r0, e0;
    logic [7:0] prev;
    r0 = ready_cnt; e0 = err_cnt; prev = scan_code;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 0, 10);
    n_vec++; if (err_cnt - e0 !== 1) begin n_miss++; $display("FAIL stop_err got=%0d exp=1", err_cnt - e0); end
    n_vec++; if (ready_cnt - r0 !== 0) begin n_miss++; $display("FAIL stop_ready got=%0d exp=0", ready_cnt - r0); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL stop_busy got=%b exp=0", busy); end
    n_vec++; if (scan_code !== prev) begin n_miss++; $display("FAIL stop_scan_code got=%h exp=%h", scan_code, prev); end
  endtask

  task automatic test_timeout();
    int r0, e0, cyc;
    logic [10:0] f;
    f = mk_frame(8'h1B, 1'b0, 1'b1);
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(f, 0, 4);
    ps2_dat = f[5];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    cyc = 0;
    while (frame_err !== 1'b1 && cyc < TO_EXPECT + 500) begin
      @(negedge clk);
      cyc++;
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    n_vec++; if (cyc !== TO_EXPECT) begin n_miss++; $display("FAIL timeout_latency got=%0d exp=%0d", cyc, TO_EXPECT); end
    repeat (HALF) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    n_vec++; if (err_cnt - e0 !== 1) begin n_miss++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
    send_bits(mk_frame(8'h23, 1'b0, 1'b1), 0, 10);
    n_vec++; if (scan_code !== 8'h23) begin n_miss++; $display("FAIL timeout_next_code got=%h exp=23", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 1) begin n_miss++; $display("FAIL timeout_next_ready got=%0d exp=1", ready_cnt - r0); end
  endtask

  task automatic test_glitch();
    int r0, e0;
    logic [10:0] f;
    r0 = ready_cnt; e0 = err_cnt;
    ps2_dat = 1'b0;
    glitch();
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL glitch_idle_busy got=%b exp=0", busy); end
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    f = mk_frame(8'hF0, 1'b0, 1'b1);
    send_bits(f, 0, 3);
    ps2_dat = f[4];
    glitch();
    send_bits(f, 4, 10);
    n_vec++; if (scan_code !== 8'hF0) begin n_miss++; $display("FAIL glitch_scan_code got=%h exp=f0", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 1) begin n_miss++; $display("FAIL glitch_ready got=%0d exp=1", ready_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_miss++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int r0, e0;
    send_bits(mk_frame(8'h1B, 1'b0, 1'b1), 0, 4);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (scan_code !== 8'h00) begin n_miss++; $display("FAIL rstmid_scan_code got=%h exp=00", scan_code); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    r0 = ready_cnt; e0 = err_cnt;
    repeat (HALF) @(negedge clk);
    send_bits(mk_frame(8'h2D, 1'b0, 1'b1), 0, 10);
    n_vec++; if (scan_code !== 8'h2D) begin n_miss++; $display("FAIL rstmid_next_code got=%h exp=2d", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 1) begin n_miss++; $display("FAIL rstmid_next_ready got=%0d exp=1", ready_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_miss++; $display("FAIL rstmid_next_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_enable();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h1B, 1'b0, 1'b1), 0, 4);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL enable_abort_busy got=%b exp=0", busy); end
    send_bits(11'h000, 0, 0);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL enable_fall_busy got=%b exp=0", busy); end
    enable = 1'b1;
    repeat (HALF) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL enable_reen_busy got=%b exp=0", busy); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_miss++; $display("FAIL enable_abort_err got=%0d exp=0", err_cnt - e0); end
    send_bits(mk_frame(8'h2D, 1'b0, 1'b1), 0, 10);
    n_vec++; if (scan_code !== 8'h2D) begin n_miss++; $display("FAIL enable_next_code got=%h exp=2d", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 1) begin n_miss++; $display("FAIL enable_next_ready got=%0d exp=1", ready_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'hE0, 1'b0, 1'b1), 0, 10);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    n_vec++; if (scan_code !== 8'h1C) begin n_miss++; $display("FAIL b2b_scan_code got=%h exp=1c", scan_code); end
    n_vec++; if (ready_cnt - r0 !== 2) begin n_miss++; $display("FAIL b2b_ready got=%0d exp=2", ready_cnt - r0); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_miss++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); end
    n_vec++; if (both_cnt !== 0) begin n_miss++; $display("FAIL ready_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    enable  = 1'b1;
    test_reset();
    test_good_frame();
    test_parity();
    test_bad_stop();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
